// File: rtl/odo_encrypt_feeder.sv
// Issue stage for odo_encrypt_loop: injects states only into free recirculation
// slots and cross-checks the loop's write strobe against the issue schedule.
module odo_encrypt_feeder #(
  parameter int unsigned WIDTH    = 640,
  parameter int unsigned RING_LEN = 18,
  parameter int unsigned LATENCY  = 178,
  parameter int unsigned CW       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] loop_in,
  output logic             loop_read,
  input  logic             loop_write,
  output logic [4:0]       inflight,
  output logic             idle,
  output logic             err
);

  localparam int unsigned PW = (RING_LEN > 1) ? $clog2(RING_LEN) : 1;
  localparam int unsigned BW = $clog2(LATENCY + 2);
  localparam logic [CW-1:0] LAT_C   = CW'(LATENCY);
  localparam logic [BW-1:0] BLANK_C = BW'(LATENCY + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(RING_LEN - 1);

  logic [PW-1:0] phase;
  logic [CW-1:0] cnt [RING_LEN];
  logic [BW-1:0] blank;
  logic          exp_q;
  logic          accept;
  logic          expiry;

  always_comb begin
    in_ready = ~rst & enable & (cnt[phase] == '0);
    accept   = in_valid & in_ready;
    idle     = (inflight == '0) & ~loop_read;
    expiry   = 1'b0;
    for (int unsigned s = 0; s < RING_LEN; s++) begin
      if (cnt[s] == CW'(1)) expiry = 1'b1;
    end
  end

  // A slot counter hits 1 on the read+LATENCY-1 cycle; exp_q realigns it to the
  // cycle the loop actually raises write (read+LATENCY).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= '0;
      for (int unsigned s = 0; s < RING_LEN; s++) cnt[s] <= '0;
      loop_in   <= '0;
      loop_read <= 1'b0;
      inflight  <= '0;
      err       <= 1'b0;
      blank     <= BLANK_C;
      exp_q     <= 1'b0;
    end else begin
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      for (int unsigned s = 0; s < RING_LEN; s++) begin
        if (accept && (PW'(s) == phase)) cnt[s] <= LAT_C;
        else if (cnt[s] != '0)           cnt[s] <= cnt[s] - 1'b1;
      end
      loop_read <= accept;
      if (accept) loop_in <= in_data;
      exp_q <= expiry;
      case ({accept, expiry})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (blank != '0)               blank <= blank - 1'b1;
      else if (loop_write != exp_q)  err   <= 1'b1;
    end
  end

endmodule
